// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and sizing helpers for the hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    HALT = 2'd2
  } state_t;

  // Freeze counter width: enough for MEM_WAIT-1, never narrower than 2 bits.
  function automatic int cnt_width(input int mem_wait);
    int w;
    w = 0;
    while ((1 << w) < (mem_wait + 1)) begin
      w = w + 1;
    end
    return (w < 2) ? 2 : w;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - load-use comparator between ID sources and the EX load
module hazard_detect (
  input  logic [2:0] rs1_adr_i,
  input  logic [2:0] rs2_adr_i,
  input  logic       rs1_use_i,
  input  logic       rs2_use_i,
  input  logic       regwrite_i,
  input  logic [2:0] regwrite_adr_i,
  input  logic       load_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  // r0 is an ordinary register, so address 0 takes part in the match
  always_comb begin
    rs1_hit    = rs1_use_i && (rs1_adr_i == regwrite_adr_i);
    rs2_hit    = rs2_use_i && (rs2_adr_i == regwrite_adr_i);
    load_use_o = regwrite_i && load_i && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard, stall, freeze and halt controller
module hazard_unit #(
  parameter int MEM_WAIT = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rs1_adr_id,
  input  logic [2:0] rs2_adr_id,
  input  logic       rs1_use_id,
  input  logic       rs2_use_id,
  input  logic       regwrite_ex,
  input  logic [2:0] regwrite_adr_ex,
  input  logic       regwrite_dat_controll_ex,
  input  logic       branch_taken_ex,
  input  logic       halt_ex,
  input  logic       mem_access_mem,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_en,
  output logic       idex_flush,
  output logic       exmem_en,
  output logic       exmem_flush,
  output logic       memwb_en,
  output logic       halted
);
  import hazard_pkg::*;

  localparam int CW         = cnt_width(MEM_WAIT);
  localparam int CNT_INIT_I = (MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0;
  localparam logic [CW-1:0] CNT_INIT  = CNT_INIT_I[CW-1:0];
  localparam logic          MEM_MULTI = (MEM_WAIT > 0);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic load_use;
  logic do_freeze;
  logic do_halt;
  logic do_branch;
  logic do_stall;

  hazard_detect u_detect (
    .rs1_adr_i      (rs1_adr_id),
    .rs2_adr_i      (rs2_adr_id),
    .rs1_use_i      (rs1_use_id),
    .rs2_use_i      (rs2_use_id),
    .regwrite_i     (regwrite_ex),
    .regwrite_adr_i (regwrite_adr_ex),
    .load_i         (regwrite_dat_controll_ex),
    .load_use_o     (load_use)
  );

  // State and freeze counter registers; reset returns to RUN from anywhere
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state plus the winning hazard; the release cycle of WAIT is RUN without the mem term
  always_comb begin
    logic eval;
    logic mem_term;
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_freeze = 1'b0;
    do_halt   = 1'b0;
    do_branch = 1'b0;
    do_stall  = 1'b0;
    eval      = 1'b0;
    mem_term  = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          eval     = 1'b1;
          mem_term = MEM_MULTI && mem_access_mem;
        end
        WAIT: begin
          if (cnt_q != '0) begin
            do_freeze = 1'b1;
            cnt_d     = cnt_q - CW'(1);
          end else begin
            eval = 1'b1;
          end
        end
        HALT: do_halt = 1'b1;
        default: state_d = RUN;
      endcase
      if (eval) begin
        state_d = RUN;
        if (mem_term) begin
          do_freeze = 1'b1;
          cnt_d     = CNT_INIT;
          state_d   = WAIT;
        end else if (halt_ex) begin
          do_halt = 1'b1;
          state_d = HALT;
        end else if (branch_taken_ex) begin
          do_branch = 1'b1;
        end else if (load_use) begin
          do_stall = 1'b1;
        end
      end
    end
  end

  // Output muxing; every flush is paired with its enable held high
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    exmem_flush = 1'b0;
    memwb_en    = 1'b1;
    halted      = !reset && (state_q == HALT);
    if (do_freeze) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (do_halt) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_flush = 1'b1;
    end else if (do_branch) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (do_stall) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit at MEM_WAIT 0, 1 and 2
module tb_hazard_unit;

  typedef struct packed {
    bit       rst;
    bit [2:0] a1;
    bit [2:0] a2;
    bit       u1;
    bit       u2;
    bit       rw;
    bit [2:0] dst;
    bit       ld;
    bit       br;
    bit       hlt;
    bit       mem;
  } stim_t;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, halted}
  localparam logic [8:0] DEF  = 9'b110101010;
  localparam logic [8:0] FRZ  = 9'b000000000;
  localparam logic [8:0] HLT  = 9'b000001110;
  localparam logic [8:0] HLTD = 9'b000001111;
  localparam logic [8:0] BR   = 9'b111111010;
  localparam logic [8:0] LU   = 9'b000111010;

  logic       clk;
  logic       reset;
  logic [2:0] rs1_adr_id, rs2_adr_id, regwrite_adr_ex;
  logic       rs1_use_id, rs2_use_id, regwrite_ex, regwrite_dat_controll_ex;
  logic       branch_taken_ex, halt_ex, mem_access_mem;
  logic [2:0] pc_en_w, ifid_en_w, ifid_flush_w, idex_en_w, idex_flush_w;
  logic [2:0] exmem_en_w, exmem_flush_w, memwb_en_w, halted_w;

  int tests_run = 0;
  int fails     = 0;

  // Reference state per instance k (MEM_WAIT = k)
  int fl [3] = '{0, 0, 0};   // freeze cycles still to come
  bit rel[3] = '{0, 0, 0};   // an access is in MEM; next non-freeze cycle is its release
  bit hm [3] = '{0, 0, 0};   // core halted

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      hazard_unit #(.MEM_WAIT(g)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .rs1_adr_id               (rs1_adr_id),
        .rs2_adr_id               (rs2_adr_id),
        .rs1_use_id               (rs1_use_id),
        .rs2_use_id               (rs2_use_id),
        .regwrite_ex              (regwrite_ex),
        .regwrite_adr_ex          (regwrite_adr_ex),
        .regwrite_dat_controll_ex (regwrite_dat_controll_ex),
        .branch_taken_ex          (branch_taken_ex),
        .halt_ex                  (halt_ex),
        .mem_access_mem           (mem_access_mem),
        .pc_en                    (pc_en_w[g]),
        .ifid_en                  (ifid_en_w[g]),
        .ifid_flush               (ifid_flush_w[g]),
        .idex_en                  (idex_en_w[g]),
        .idex_flush               (idex_flush_w[g]),
        .exmem_en                 (exmem_en_w[g]),
        .exmem_flush              (exmem_flush_w[g]),
        .memwb_en                 (memwb_en_w[g]),
        .halted                   (halted_w[g])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] obs_of(input int k);
    return {pc_en_w[k], ifid_en_w[k], ifid_flush_w[k], idex_en_w[k], idex_flush_w[k],
            exmem_en_w[k], exmem_flush_w[k], memwb_en_w[k], halted_w[k]};
  endfunction

  function automatic logic [8:0] model_out(input int k);
    bit lu;
    lu = regwrite_ex && regwrite_dat_controll_ex &&
         ((rs1_use_id && rs1_adr_id == regwrite_adr_ex) ||
          (rs2_use_id && rs2_adr_id == regwrite_adr_ex));
    if (reset) return DEF;
    if (hm[k]) return HLTD;
    if (fl[k] > 0) return FRZ;
    if (!rel[k] && mem_access_mem && k > 0) return FRZ;
    if (halt_ex) return HLT;
    if (branch_taken_ex) return BR;
    if (lu) return LU;
    return DEF;
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (reset) begin
        fl[k] = 0; rel[k] = 0; hm[k] = 0;
      end else if (hm[k]) begin
        hm[k] = 1;
      end else if (fl[k] > 0) begin
        fl[k] = fl[k] - 1;
      end else if (!rel[k] && mem_access_mem && k > 0) begin
        fl[k] = k - 1; rel[k] = 1;
      end else begin
        rel[k] = 0;
        if (halt_ex) hm[k] = 1;
      end
    end
  endtask

  task automatic apply(input stim_t s);
    reset = s.rst; rs1_adr_id = s.a1; rs2_adr_id = s.a2;
    rs1_use_id = s.u1; rs2_use_id = s.u2; regwrite_ex = s.rw;
    regwrite_adr_ex = s.dst; regwrite_dat_controll_ex = s.ld;
    branch_taken_ex = s.br; halt_ex = s.hlt; mem_access_mem = s.mem;
  endtask

  function automatic stim_t rand_stim(input bit allow_rst);
    stim_t s;
    s.rst = allow_rst && ($urandom_range(0, 19) == 0);
    s.a1  = 3'($urandom_range(0, 3));
    s.a2  = 3'($urandom_range(0, 3));
    s.u1  = 1'($urandom);
    s.u2  = 1'($urandom);
    s.rw  = 1'($urandom);
    s.dst = 3'($urandom_range(0, 3));
    s.ld  = 1'($urandom);
    s.br  = ($urandom_range(0, 4) == 0);
    s.hlt = ($urandom_range(0, 24) == 0);
    s.mem = ($urandom_range(0, 3) == 0);
    return s;
  endfunction

  task automatic test_reset();
    stim_t q[$];
    q.push_back(rand_stim(0)); q.push_back(rand_stim(0));
    foreach (q[i]) begin
      q[i].rst = 1'b1; q[i].hlt = 1'b1; q[i].mem = 1'b1;
      apply(q[i]); @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (obs_of(k) !== model_out(k)) begin
          fails++; $display("FAIL reset cyc%0d W=%0d got %b exp %b", i, k, obs_of(k), model_out(k));
        end
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_load_use();
    stim_t q[$]; stim_t s;
    s = '0; s.rw = 1; s.ld = 1; s.dst = 3; s.a2 = 3; s.u2 = 1; q.push_back(s); q.push_back('0);
    s.u2 = 0; q.push_back(s);
    s.dst = 0; s.a1 = 0; s.u1 = 1; q.push_back(s);
    s.ld = 0; q.push_back(s);
    s.ld = 1; s.rw = 0; q.push_back(s);
    s.rw = 1; s.a1 = 5; s.a2 = 6; s.u2 = 1; q.push_back(s); q.push_back('0);
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (obs_of(k) !== model_out(k)) begin
          fails++; $display("FAIL load_use cyc%0d W=%0d got %b exp %b", i, k, obs_of(k), model_out(k));
        end
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_priority();
    stim_t q[$]; stim_t s;
    s = '0; s.rw = 1; s.ld = 1; s.dst = 2; s.a1 = 2; s.u1 = 1; s.br = 1; q.push_back(s);
    s.hlt = 1; s.rst = 0; q.push_back(s);
    s.rst = 1; q.push_back(s);
    s = '0; s.br = 1; s.mem = 1; q.push_back(s);
    s = '0; s.rst = 1; q.push_back(s); q.push_back('0);
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (obs_of(k) !== model_out(k)) begin
          fails++; $display("FAIL priority cyc%0d W=%0d got %b exp %b", i, k, obs_of(k), model_out(k));
        end
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_mem_freeze();
    stim_t q[$]; stim_t s;
    s = '0; s.mem = 1; q.push_back(s);
    repeat (4) q.push_back('0);
    repeat (7) q.push_back(s);
    q.push_back('0);
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (obs_of(k) !== model_out(k)) begin
          fails++; $display("FAIL mem_freeze cyc%0d W=%0d got %b exp %b", i, k, obs_of(k), model_out(k));
        end
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_branch_in_wait();
    stim_t q[$]; stim_t s;
    s = '0; s.mem = 1; q.push_back(s);
    s = '0; s.br = 1; q.push_back(s); q.push_back(s);
    q.push_back('0);
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (obs_of(k) !== model_out(k)) begin
          fails++; $display("FAIL branch_in_wait cyc%0d W=%0d got %b exp %b", i, k, obs_of(k), model_out(k));
        end
      end
      @(posedge clk); model_step(); #1;
    end
    tests_run++;
    if (model_out(2) !== DEF || obs_of(2) !== DEF) begin
      fails++; $display("FAIL branch_in_wait_end got %b exp %b", obs_of(2), DEF);
    end
  endtask

  task automatic test_reset_in_wait();
    stim_t q[$]; stim_t s;
    s = '0; s.mem = 1; q.push_back(s);
    s = '0; s.rst = 1; s.br = 1; q.push_back(s);
    q.push_back('0); q.push_back('0);
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (obs_of(k) !== model_out(k)) begin
          fails++; $display("FAIL reset_in_wait cyc%0d W=%0d got %b exp %b", i, k, obs_of(k), model_out(k));
        end
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      apply(rand_stim(1)); @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (obs_of(k) !== model_out(k)) begin
          fails++; $display("FAIL random cyc%0d W=%0d got %b exp %b", i, k, obs_of(k), model_out(k));
        end
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_halt();
    stim_t q[$]; stim_t s;
    s = '0; s.rst = 1; q.push_back(s);
    s = '0; s.hlt = 1; q.push_back(s);
    repeat (12) q.push_back(rand_stim(0));
    foreach (q[i]) begin
      apply(q[i]); @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (obs_of(k) !== model_out(k)) begin
          fails++; $display("FAIL halt cyc%0d W=%0d got %b exp %b", i, k, obs_of(k), model_out(k));
        end
      end
      @(posedge clk); model_step(); #1;
    end
    tests_run++;
    if (halted_w !== 3'b111) begin
      fails++; $display("FAIL halt_sticky got %b exp 111", halted_w);
    end
  endtask

  initial begin
    apply('0);
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_priority();
    test_mem_freeze();
    test_branch_in_wait();
    test_reset_in_wait();
    test_random();
    test_halt();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
